// File: rtl/fft_sdf_sequencer.sv
// Control sequencer for a radix-2 SDF FFT pipeline. A single sample counter
// drives the shared advance enable, every stage's butterfly/twiddle control and the flush.
module fft_sdf_sequencer #(
   parameter int LOG2N = 5,
   parameter int PIPE  = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         adv,
   output logic                         zero_in,
   output logic [LOG2N-1:0]             bf_sel,
   output logic [LOG2N*(LOG2N-1)-1:0]   tw_addr,
   output logic                         out_valid,
   output logic                         out_sop,
   output logic                         busy
);

   localparam int N       = 1 << LOG2N;
   localparam int LATENCY = N - 1 + LOG2N * PIPE;
   localparam int CW      = $clog2(LATENCY + 1);
   localparam int TW      = LOG2N - 1;

   localparam logic [CW-1:0]    LAT_C      = CW'(LATENCY);
   localparam logic [CW-1:0]    LAST_FLUSH = CW'(LATENCY - 1);
   localparam logic [LOG2N-1:0] SOP_CNT    = LOG2N'(LATENCY % N);

   typedef enum logic [1:0] {IDLE, RUN, PAD, DRAIN} state_t;

   state_t           state_q, state_d;
   logic [LOG2N-1:0] cnt_q, cnt_d;
   logic [CW-1:0]    prime_q, prime_d;
   logic [CW-1:0]    flush_q, flush_d;

   // Advances from the first input sample until stage k sees its first valid sample.
   function automatic logic [CW-1:0] stage_off(input int k);
      return CW'(N - (N >> k) + k * PIPE);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prime_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prime_q <= prime_d;
         flush_q <= flush_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      adv      = 1'b0;
      zero_in  = 1'b0;
      flush_d  = '0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            // Held in reset the FSM sits in IDLE; keep the pipeline frozen then.
            adv      = in_valid & rst_n;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            adv      = in_valid;
            if (!in_valid) state_d = (cnt_q == '0) ? DRAIN : PAD;
         end
         PAD: begin
            adv     = 1'b1;
            zero_in = 1'b1;
            if (cnt_q == '1) state_d = DRAIN;
         end
         DRAIN: begin
            adv     = 1'b1;
            zero_in = 1'b1;
            flush_d = flush_q + 1'b1;
            if (flush_q == LAST_FLUSH) begin
               state_d = IDLE;
               flush_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      cnt_d   = adv ? cnt_q + 1'b1 : cnt_q;
      prime_d = (adv && prime_q != LAT_C) ? prime_q + 1'b1 : prime_q;
      if (state_q == DRAIN && state_d == IDLE) begin
         cnt_d   = '0;
         prime_d = '0;
      end
   end

   logic [CW-1:0]    off;
   logic [LOG2N-1:0] loc;
   logic [TW-1:0]    tw;
   logic             primed;

   // Stage k runs the same counter delayed by its offset; bit (LOG2N-1-k) of the
   // delayed count selects the butterfly half, the bits below it index the twiddle.
   always_comb begin
      bf_sel  = '0;
      tw_addr = '0;
      off     = '0;
      loc     = '0;
      tw      = '0;
      primed  = 1'b0;
      for (int k = 0; k < LOG2N; k++) begin
         off       = stage_off(k);
         primed    = prime_q > off;
         loc       = cnt_q - off[LOG2N-1:0];
         bf_sel[k] = primed & loc[LOG2N-1-k];
         tw        = loc[TW-1:0] << k;
         if (primed && !loc[LOG2N-1-k]) tw_addr[k*TW +: TW] = tw;
      end
   end

   assign out_valid = adv & (prime_q >= LAT_C);
   assign out_sop   = out_valid & (cnt_q == SOP_CNT);
   assign busy      = (state_q != IDLE);

endmodule

// File: doc/fft_sdf_sequencer.md
Name: fft_sdf_sequencer

Overview:
- Central control sequencer for the radix-2 single-path delay-feedback (SDF) FFT pipeline: one butterfly stage per log2 level, each with a delay line and a twiddle ROM.
- Generates from one sample counter:
  - the shared pipeline advance enable;
  - per-stage butterfly select;
  - per-stage twiddle ROM address;
  - input back-pressure;
  - output frame framing.
- Drives a zero-padded flush so the last frame drains without further input.
- Replaces per-stage free-running counters inside the twiddle ROMs; ROMs become pure address-to-coefficient lookups.

Parameters:
- LOG2N, 5, log2 of FFT size; N = 2**LOG2N = 32.
- PIPE, 1, register stages per butterfly stage after its delay line.
- LATENCY, derived = N-1 + LOG2N*PIPE (36 at defaults): advances from first input sample to first output sample.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input sample present; accepted only when in_ready=1.
- in_ready  out  1  sequencer accepts input.
- adv  out  1  pipeline enable; every datapath register and delay line shifts only when adv=1.
- zero_in  out  1  datapath substitutes 0 for the input sample (flush padding).
- bf_sel  out  LOG2N  bit k=1: stage k in butterfly phase (sum out, difference into delay line). bit k=0: pass/twiddle phase.
- tw_addr  out  LOG2N*(LOG2N-1)  packed; field k = bits [k*(LOG2N-1) +: LOG2N-1]; twiddle index for stage k's ROM.
- out_valid  out  1  pipeline output sample valid this cycle.
- out_sop  out  1  first sample of an output frame; qualified by out_valid.
- busy  out  1  state != IDLE.

Behaviour:

Reset:
- Asynchronous reset sets state=IDLE, cnt=0, prime counter=0, flush counter=0.
- Outputs after reset: adv=0, zero_in=0, bf_sel=0, tw_addr=0, out_valid=0, out_sop=0, busy=0, in_ready=1.
- Reset mid-operation discards all in-flight data. There is no partial flush.

FSM states IDLE, RUN, PAD, DRAIN:
- IDLE:
  - in_ready=1.
  - in_valid=1: adv=1 this cycle, next state RUN.
- RUN:
  - in_ready=1, adv=in_valid.
  - in_valid=0 with cnt!=0 (mid-frame): next state PAD.
  - in_valid=0 with cnt==0 (frame boundary): next state DRAIN.
- PAD:
  - in_ready=0, adv=1, zero_in=1.
  - Stays until cnt wraps to 0, then goes to DRAIN.
- DRAIN:
  - in_ready=0, adv=1, zero_in=1.
  - Lasts exactly LATENCY cycles (flush counter), then goes to IDLE.
  - On entry to IDLE: cnt=0, prime counter=0.

Counters and arithmetic:
- in_valid while in_ready=0 is ignored; the source holds it until in_ready=1.
- cnt: LOG2N bits, increments mod N on every adv.
- prime counter: counts adv, saturates at LATENCY.
- Stage offset OFF_k = N - (N>>k) + k*PIPE. Defaults: 0, 17, 26, 31, 34.
- primed_k = prime counter > OFF_k, evaluated before this cycle's increment. Example: at the first adv, prime counter=0, so primed_0=0.
- local_k = (cnt - OFF_k) mod N.
- D_k = N>>(k+1).

Per-stage outputs:
- bf_sel[k] = primed_k & (local_k mod 2D_k >= D_k).
- tw_addr field k = ((local_k mod D_k) << k), truncated to LOG2N-1 bits, when primed_k & !bf_sel[k]; else 0.
- Stage LOG2N-1 therefore always has tw_addr 0.
- All control outputs are combinational from registered state/counters and in_valid. They apply to the same cycle's adv.

Output framing:
- out_valid = adv & (prime counter >= LATENCY).
- out_sop = out_valid & (cnt == LATENCY mod N). Default: cnt==4.
- Output order is bit-reversed; reordering is not this block's job.

Boundary conditions:
- Single-cycle in_valid gap mid-frame enters PAD. The frame is padded, not stalled; the source must send whole frames contiguously.
- Prime counter saturation keeps out_valid asserted across back-to-back frames indefinitely.

Test Plan:
- Reset: rst_n low with in_valid=1 -> in_ready=1, adv=0, bf_sel=0, tw_addr=0, out_valid=0, busy=0; clean behaviour after async deassert.
- 32 contiguous in_valid from IDLE:
  - stage 0: first adv has bf_sel[0]=0 and tw_addr0=0; advances 2-16 have bf_sel[0]=0, tw_addr0=1..15; advances 17-32 have bf_sel[0]=1, tw_addr0=0.
  - stage 1: first bf_sel[1]=1 at advance 26.
  - stage 4: bf_sel[4] first 1 at advance 36.
- Two contiguous frames, in_valid drops at frame boundary -> DRAIN 36 cycles with in_ready=0, zero_in=1; exactly 64 out_valid pulses; out_sop at advances 37 and 69; then IDLE, busy=0.
- in_valid drops after 10 samples -> PAD 22 cycles then DRAIN 36 (58 cycles in_ready=0); 32 out_valid pulses.
- in_valid held high throughout DRAIN -> no extra adv; new frame accepted the first IDLE cycle with adv=1, cnt restarted at 0.
- rst_n asserted mid-DRAIN -> all outputs at reset values immediately; next frame behaves as from power-up (first bf_sel[0]=1 at advance 17).
